// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Serial bit-stream transmitter. Accepts a parallel word over a
//               valid/ready handshake and shifts it out MSB-first on w, one
//               bit per DIV-cycle bit period. It also keeps a saturating count
//               of the "0011" sequences that appear on w.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int WIDTH    = 8,
    parameter int DIV      = 4,
    parameter bit IDLE_LVL = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pattern_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DIV_W = $clog2(DIV);
    localparam int c_IDX_W = $clog2(WIDTH);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ARMED = 2'd1;
    localparam logic [1:0] c_S_SHIFT = 2'd2;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_last_bit;

    logic [WIDTH-1:0]   r_shreg;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic               r_w;
    logic               r_bit_strobe;
    logic               r_done;

    // Only the three newest history bits are ever compared against the
    // incoming value, so the oldest of the four-bit window is not stored.
    logic [2:0]         r_hist;
    logic [3:0]         w_window;
    logic [CNT_W-1:0]   r_pattern_cnt;

    assign w_tick     = (r_div_cnt == c_DIV_LAST);
    assign w_accept   = load_valid && (r_state == c_S_IDLE);
    assign w_last_bit = (r_bit_idx == '0);
    assign w_window   = {r_hist, r_w};

    assign w           = r_w;
    assign bit_strobe  = r_bit_strobe;
    assign done        = r_done;
    assign pattern_cnt = r_pattern_cnt;

    // Free-running bit-period divider; restarts from zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: accept is tick-independent, bit moves wait for tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_ARMED;
                end
            end
            c_S_ARMED: begin
                if (w_tick) begin
                    w_state_nxt = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (w_tick && w_last_bit) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        case (r_state)
            c_S_IDLE:  load_ready = 1'b1;
            c_S_ARMED: busy       = 1'b1;
            c_S_SHIFT: busy       = 1'b1;
            default: begin
                load_ready = 1'b0;
                busy       = 1'b0;
            end
        endcase
    end

    // Shift datapath: capture on accept, drive one bit per tick, then return to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_w          <= IDLE_LVL;
            r_bit_strobe <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_bit_strobe <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= load_data;
                    end
                end
                c_S_ARMED: begin
                    if (w_tick) begin
                        r_w          <= r_shreg[WIDTH-1];
                        r_shreg      <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_bit_idx    <= c_IDX_LAST;
                        r_bit_strobe <= 1'b1;
                    end
                end
                c_S_SHIFT: begin
                    if (w_tick) begin
                        r_bit_strobe <= 1'b1;
                        if (!w_last_bit) begin
                            r_w       <= r_shreg[WIDTH-1];
                            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                            r_bit_idx <= r_bit_idx - c_IDX_W'(1);
                        end else begin
                            // The idle-level period that follows guarantees
                            // a gap of at least one bit between words.
                            r_w    <= IDLE_LVL;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_w <= IDLE_LVL;
                end
            endcase
        end
    end

    // Pattern monitor: sample w once per bit period and count saturating "0011" hits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // All-ones history keeps post-reset idle zeros from faking a match.
            r_hist        <= 3'b111;
            r_pattern_cnt <= '0;
        end else if (w_tick) begin
            r_hist <= w_window[2:0];
            if ((w_window == 4'b0011) && (r_pattern_cnt != c_CNT_MAX)) begin
                r_pattern_cnt <= r_pattern_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_pattern_tx
// Description : Directed self-checking bench for serial_pattern_tx. Three
//               instances cover the default build, a 2-bit saturating
//               counter, and a DIV=2 / idle-high build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

    localparam int c_DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // default instance
    logic [7:0]  m_data  = '0;
    logic        m_valid = 1'b0;
    logic        m_ready, m_w, m_strobe, m_busy, m_done;
    logic [15:0] m_cnt;

    // saturation instance (CNT_W=2)
    logic [7:0]  s_data  = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, s_w, s_strobe, s_busy, s_done;
    logic [1:0]  s_cnt;

    // divider / idle-level instance (DIV=2, IDLE_LVL=1)
    logic [7:0]  d_data  = '0;
    logic        d_valid = 1'b0;
    logic        d_ready, d_w, d_strobe, d_busy, d_done;
    logic [15:0] d_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    serial_pattern_tx #(.WIDTH(8), .DIV(4), .IDLE_LVL(1'b0), .CNT_W(16)) dut (
        .clk(clk), .reset(rst_n), .load_data(m_data), .load_valid(m_valid),
        .load_ready(m_ready), .w(m_w), .bit_strobe(m_strobe), .busy(m_busy),
        .done(m_done), .pattern_cnt(m_cnt)
    );

    serial_pattern_tx #(.WIDTH(8), .DIV(4), .IDLE_LVL(1'b0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(rst_n), .load_data(s_data), .load_valid(s_valid),
        .load_ready(s_ready), .w(s_w), .bit_strobe(s_strobe), .busy(s_busy),
        .done(s_done), .pattern_cnt(s_cnt)
    );

    serial_pattern_tx #(.WIDTH(8), .DIV(2), .IDLE_LVL(1'b1), .CNT_W(16)) dut_div (
        .clk(clk), .reset(rst_n), .load_data(d_data), .load_valid(d_valid),
        .load_ready(d_ready), .w(d_w), .bit_strobe(d_strobe), .busy(d_busy),
        .done(d_done), .pattern_cnt(d_cnt)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Async reset asserted away from the clock edge, then released on a negedge.
    task automatic do_reset();
        m_valid = 1'b0;
        s_valid = 1'b0;
        d_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_w",      32'(m_w),      32'd0);
        check("rst_ready",  32'(m_ready),  32'd1);
        check("rst_busy",   32'(m_busy),   32'd0);
        check("rst_done",   32'(m_done),   32'd0);
        check("rst_strobe", 32'(m_strobe), 32'd0);
        check("rst_cnt",    32'(m_cnt),    32'd0);
        check("rst_sat_cnt", 32'(s_cnt),   32'd0);
        check("rst_div_w",  32'(d_w),      32'd1);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Present a word on the default instance and wait for it to be taken.
    task automatic send_main(input string tag, input logic [7:0] d, input bit hold);
        int n;
        m_data  = d;
        m_valid = 1'b1;
        n = 0;
        do begin
            step();
            n = n + 1;
        end while (!m_busy && n < 64);
        check({tag, "_accept"}, 32'(m_busy), 32'd1);
        if (!hold) m_valid = 1'b0;
    endtask

    // Wait for the MSB strobe, checking w stays idle-low meanwhile; returns cycles waited.
    task automatic wait_strobe(input string tag, output int n);
        n = 0;
        while (m_strobe !== 1'b1 && n < 2 * c_DIV) begin
            check({tag, "_gap_w"}, 32'(m_w), 32'd0);
            step();
            n = n + 1;
        end
        check({tag, "_msb_strobe"}, 32'(m_strobe), 32'd1);
    endtask

    // Starting in the MSB strobe cycle: verify every bit, its hold time, and the done cycle.
    task automatic check_bits(input string tag, input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("%s_b%0d_strobe", tag, i), 32'(m_strobe), 32'd1);
            check($sformatf("%s_b%0d_w", tag, i),      32'(m_w),      32'(d[i]));
            check($sformatf("%s_b%0d_ready", tag, i),  32'(m_ready),  32'd0);
            check($sformatf("%s_b%0d_busy", tag, i),   32'(m_busy),   32'd1);
            check($sformatf("%s_b%0d_done", tag, i),   32'(m_done),   32'd0);
            for (int k = 1; k < c_DIV; k++) begin
                step();
                check($sformatf("%s_b%0d_hold_w", tag, i),  32'(m_w),      32'(d[i]));
                check($sformatf("%s_b%0d_hold_st", tag, i), 32'(m_strobe), 32'd0);
                check($sformatf("%s_b%0d_hold_rdy", tag, i), 32'(m_ready), 32'd0);
            end
            step();
        end
        check({tag, "_done"},       32'(m_done),   32'd1);
        check({tag, "_end_strobe"}, 32'(m_strobe), 32'd1);
        check({tag, "_end_w"},      32'(m_w),      32'd0);
        check({tag, "_end_ready"},  32'(m_ready),  32'd1);
        check({tag, "_end_busy"},   32'(m_busy),   32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] pat;

        // 1. Basic word 0x33: two matches, then idle low with no strobes.
        do_reset();
        send_main("t1", 8'h33, 1'b0);
        wait_strobe("t1", n);
        check("t1_latency", 32'(n), 32'd3);
        check_bits("t1", 8'h33);
        check("t1_cnt", 32'(m_cnt), 32'd2);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_idle_w",      32'(m_w),      32'd0);
            check("t1_idle_strobe", 32'(m_strobe), 32'd0);
            check("t1_idle_done",   32'(m_done),   32'd0);
        end

        // 2. 0xFC then 0xC0 back-to-back: exactly one idle bit, one cross-boundary match.
        do_reset();
        send_main("t2a", 8'hFC, 1'b0);
        wait_strobe("t2a", n);
        check_bits("t2a", 8'hFC);
        send_main("t2b", 8'hC0, 1'b0);
        wait_strobe("t2b", n);
        check("t2_idle_gap", 32'(n), 32'd3);
        check_bits("t2b", 8'hC0);
        check("t2_cnt", 32'(m_cnt), 32'd1);

        // 3. Valid held high, data changed to 0xFF during SHIFT of 0x0F.
        do_reset();
        send_main("t3a", 8'h0F, 1'b1);
        wait_strobe("t3a", n);
        m_data = 8'hFF;
        check_bits("t3a", 8'h0F);
        send_main("t3b", 8'hFF, 1'b0);
        wait_strobe("t3b", n);
        check_bits("t3b", 8'hFF);
        check("t3_cnt", 32'(m_cnt), 32'd1);

        // 4. Reset during the third bit of 0xA5, then a clean 0x33.
        do_reset();
        send_main("t4a", 8'hA5, 1'b0);
        wait_strobe("t4a", n);
        repeat (2 * c_DIV) step();
        check("t4_third_strobe", 32'(m_strobe), 32'd1);
        check("t4_third_w",      32'(m_w),      32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("t4_rst_w",     32'(m_w),      32'd0);
        check("t4_rst_busy",  32'(m_busy),   32'd0);
        check("t4_rst_ready", 32'(m_ready),  32'd1);
        check("t4_rst_cnt",   32'(m_cnt),    32'd0);
        check("t4_rst_done",  32'(m_done),   32'd0);
        check("t4_rst_st",    32'(m_strobe), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        send_main("t4b", 8'h33, 1'b0);
        wait_strobe("t4b", n);
        check("t4_latency", 32'(n), 32'd3);
        check_bits("t4b", 8'h33);
        check("t4_cnt", 32'(m_cnt), 32'd2);

        // 5. Four 0x33 words on the 2-bit counter: 2, then saturated at 3.
        do_reset();
        s_data  = 8'h33;
        s_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            do begin
                step();
                n = n + 1;
            end while (!s_done && n < 200);
            check($sformatf("t5_done%0d", k), 32'(s_done), 32'd1);
            check($sformatf("t5_cnt%0d", k),  32'(s_cnt),  (k == 1) ? 32'd2 : 32'd3);
        end
        s_valid = 1'b0;
        repeat (20) step();
        check("t5_cnt_hold", 32'(s_cnt), 32'd3);

        // 6. DIV=2, idle-high: 0x0C, two-cycle bits, one in-word match.
        do_reset();
        pat     = 8'h0C;
        d_data  = pat;
        d_valid = 1'b1;
        n = 0;
        do begin
            step();
            n = n + 1;
        end while (!d_busy && n < 64);
        d_valid = 1'b0;
        check("t6_accept", 32'(d_busy), 32'd1);
        n = 0;
        while (d_strobe !== 1'b1 && n < 8) begin
            check("t6_gap_w", 32'(d_w), 32'd1);
            step();
            n = n + 1;
        end
        check("t6_latency", 32'(n), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("t6_b%0d_strobe", i), 32'(d_strobe), 32'd1);
            check($sformatf("t6_b%0d_w", i),      32'(d_w),      32'(pat[i]));
            step();
            check($sformatf("t6_b%0d_hold_w", i),  32'(d_w),      32'(pat[i]));
            check($sformatf("t6_b%0d_hold_st", i), 32'(d_strobe), 32'd0);
            step();
        end
        check("t6_done",  32'(d_done),  32'd1);
        check("t6_end_w", 32'(d_w),     32'd1);
        check("t6_ready", 32'(d_ready), 32'd1);
        check("t6_cnt",   32'(d_cnt),   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter that drives the `w` input of the Moore "0011" sequence detector. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per bit period. The bit period is generated by an internal clock-enable divider, so the block and the detector share one clock. The block also counts the "0011" occurrences it transmits, giving the detector bench a golden count to compare against.

## Interface
Parameters:
- `WIDTH`, default 8: word length in bits; legal range ≥ 4.
- `DIV`, default 4: bit period in `clk` cycles; legal range ≥ 2.
- `IDLE_LVL`, default 0: value driven on `w` when no word is being sent.
- `CNT_W`, default 16: width of `pattern_cnt`.

Ports:
- `clk`, input, 1: the single clock; all state is updated on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset).
- `load_data`, input, `WIDTH`: word to transmit.
- `load_valid`, input, 1: `load_data` is valid.
- `load_ready`, output, 1: block can accept a word.
- `w`, output, 1: registered serial output.
- `bit_strobe`, output, 1: one-`clk` pulse in the cycle a new bit period starts on `w`.
- `busy`, output, 1: high in ARMED and SHIFT.
- `done`, output, 1: one-`clk` pulse when the last bit period of a word ends.
- `pattern_cnt`, output, `CNT_W`: saturating count of "0011" sequences seen on `w`.

## Operation
- **Divider.** `div_cnt` counts 0..DIV-1 freely from reset and wraps to 0. `tick = (div_cnt == DIV-1)`. Every bit-level action happens only on a clock edge where `tick` is 1.
- **FSM states:** IDLE, ARMED, SHIFT.
  - **IDLE:** `load_ready`=1 and `w`=IDLE_LVL. On `load_valid`&&`load_ready`, capture `load_data` into `shreg` and go to ARMED. This does not depend on `tick`.
  - **ARMED:** `load_ready`=0. On the next tick: `w`←`shreg[WIDTH-1]`, shift `shreg` left, `bit_idx`←WIDTH-1, go to SHIFT.
  - **SHIFT:** on each tick, if `bit_idx`≠0: `w`←next MSB and `bit_idx`←`bit_idx`-1. If `bit_idx`==0: `w`←IDLE_LVL, `done` pulses, go to IDLE.
- `load_ready` is asserted only in IDLE. `load_valid` in any other state is ignored, and the `load_data` value at that time has no effect.
- Consecutive words are always separated by at least one IDLE_LVL bit period.
- `bit_strobe` is registered. It is 1 in the cycle after every tick edge that loads a data bit, and also after the tick edge that returns `w` to IDLE_LVL.
- **Pattern counter.**
  - `hist[3:0]` shifts in the current value of `w` on every tick, in every state, idle bits included.
  - When the new value `{hist[2:0], w}` equals 4'b0011 (oldest to newest 0,0,1,1), `pattern_cnt` increments.
  - `pattern_cnt` saturates at 2^CNT_W-1.
  - Matches that span word boundaries and idle bits are counted.
- **Reset.** Asserting `reset` at any time, including mid-word, immediately forces:
  - state=IDLE, `div_cnt`=0, `shreg`=0, `bit_idx`=0
  - `hist`=4'b1111, `pattern_cnt`=0
  - `w`=IDLE_LVL, `load_ready`=1 (combinational from IDLE), `busy`=0, `done`=0, `bit_strobe`=0
  - The word in flight is discarded. After reset release, the divider restarts from 0.

## Timing
- First tick occurs in the DIV-th cycle after reset release. Subsequent ticks occur every DIV cycles.
- **Latency:** accept at edge t. MSB appears on `w` after the first tick edge after t, i.e. 1 to DIV cycles later.
- Each data bit is held exactly DIV cycles.
- `done` and the return to IDLE_LVL occur WIDTH·DIV cycles after the MSB edge.
- `load_ready` rises in the same cycle `done` is high.
- **Simultaneous events:**
  - accept while `tick`=1 in IDLE: go to ARMED, and wait for the *next* tick.
  - `reset` asserted while `tick`=1: reset wins.

## Test plan
Settings for all scenarios: WIDTH=8, DIV=4, IDLE_LVL=0 unless noted.

1. **Basic word.** After reset, load 8'h33. Required: `w` = 0,0,1,1,0,0,1,1, each bit held 4 clks; `bit_strobe` at each bit change; `done` after 32 clks from the MSB; then `w`=0; `pattern_cnt`=2.
2. **Cross-boundary match.** Load 8'hFC, then 8'hC0 as soon as `load_ready` rises. Required: at least one idle 0 between the words; exactly 1 match (…0,0,idle 0,1,1); `pattern_cnt`=1.
3. **Handshake.** Hold `load_valid`=1 and change `load_data` to 8'hFF during SHIFT of 8'h0F. Required: `load_ready`=0 throughout SHIFT; transmitted bits are 0,0,0,0,1,1,1,1; the 8'hFF word is sent only after the handshake completes in IDLE.
4. **Reset mid-word.** Assert `reset` during the third bit of 8'hA5. Required, in that same cycle: `w`=0, `busy`=0, `load_ready`=1, `pattern_cnt`=0. After release, a new 8'h33 is transmitted correctly.
5. **Saturation (CNT_W=2).** Send four 8'h33 words. Required: `pattern_cnt` reaches 3 and holds at 3.
6. **Divider and idle level (DIV=2, IDLE_LVL=1).** Load 8'h0C. Required: each bit is held 2 clks; `w`=1 when idle; 1 match from the 0,0,1,1 inside the word.
